// File: rtl/axioma_adc_trigger.sv
// axioma_adc_trigger
//
// ADC auto-trigger source selector and event arbiter. Selects one of eight
// trigger sources (ADTS encoding), detects rising edges of the selected flag,
// holds at most one pending trigger while the ADC is converting, flags lost
// events as overruns and counts issued triggers.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   aden, adate           ADC enable / auto-trigger enable; both 1 = armed
//   adts[2:0]             trigger source select
//   adc_busy, adc_done    ADC status: converting / one-cycle completion pulse
//   src_*                 trigger source flags (levels)
//   overrun_clr           clears the sticky overrun flag
//   adc_trigger           registered one-cycle trigger pulse to the ADC
//   trig_pending          a trigger is held waiting for the ADC
//   overrun               sticky: an event was lost
//   trig_count[7:0]       wrapping count of issued triggers
//
// Build option: define AXIOMA_ADC_TRIG_SYNC_EN to pass src_int0 through a
// 2-flop synchronizer (adds two cycles of INT0 latency).

module axioma_adc_trigger (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       aden,
  input  logic       adate,
  input  logic [2:0] adts,
  input  logic       adc_busy,
  input  logic       adc_done,
  input  logic       src_acomp,
  input  logic       src_int0,
  input  logic       src_t0_compa,
  input  logic       src_t0_ovf,
  input  logic       src_t1_compb,
  input  logic       src_t1_ovf,
  input  logic       src_t1_capt,
  input  logic       overrun_clr,
  output logic       adc_trigger,
  output logic       trig_pending,
  output logic       overrun,
  output logic [7:0] trig_count
);

  logic       int0_sel;
  logic [7:0] src_vec;
  logic       sel;
  logic       adts_changed;
  logic       event_det;
  logic       armed;
  logic       busy_eff;
  logic       issue;
  logic       overrun_set;

  logic [2:0] adts_q,    adts_d;
  logic       prev_q,    prev_d;
  logic       guard_q,   guard_d;
  logic       pending_q, pending_d;
  logic       trig_q,    trig_d;
  logic       overrun_q, overrun_d;
  logic [7:0] count_q,   count_d;

`ifdef AXIOMA_ADC_TRIG_SYNC_EN
  logic int0_s1_q, int0_s2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int0_s1_q <= 1'b0;
      int0_s2_q <= 1'b0;
    end else begin
      int0_s1_q <= src_int0;
      int0_s2_q <= int0_s1_q;
    end
  end

  assign int0_sel = int0_s2_q;
`else
  assign int0_sel = src_int0;
`endif

  // Index 0 carries adc_done so free-running mode shares the select path.
  assign src_vec = {src_t1_capt, src_t1_ovf, src_t1_compb, src_t0_ovf,
                    src_t0_compa, int0_sel, src_acomp, adc_done};
  assign sel     = src_vec[adts];

  assign adts_changed = (adts != adts_q);
  assign armed        = aden & adate;
  // guard bridges the cycle between issuing a trigger and the ADC going busy.
  assign busy_eff     = adc_busy | guard_q;

  always_comb begin
    if (adts_changed) begin
      event_det = 1'b0;
    end else if (adts == 3'd0) begin
      event_det = adc_done;
    end else begin
      event_det = sel & ~prev_q;
    end
  end

  always_comb begin
    adts_d      = adts;
    prev_d      = sel;
    issue       = 1'b0;
    overrun_set = 1'b0;
    pending_d   = pending_q;
    guard_d     = guard_q;

    if (!armed) begin
      pending_d = 1'b0;
      guard_d   = 1'b0;
    end else begin
      if (!busy_eff) begin
        if (pending_q) begin
          issue     = 1'b1;
          // A coincident event re-arms the pending slot.
          pending_d = event_det;
        end else if (event_det) begin
          issue = 1'b1;
        end
      end else if (event_det) begin
        if (pending_q) begin
          overrun_set = 1'b1;
        end else begin
          pending_d = 1'b1;
        end
      end

      if (issue) begin
        guard_d = 1'b1;
      end else if (adc_busy) begin
        guard_d = 1'b0;
      end
    end

    trig_d    = issue;
    overrun_d = overrun_set | (overrun_q & ~overrun_clr);
    count_d   = count_q + {7'd0, issue};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adts_q    <= 3'd0;
      prev_q    <= 1'b0;
      guard_q   <= 1'b0;
      pending_q <= 1'b0;
      trig_q    <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      adts_q    <= adts_d;
      prev_q    <= prev_d;
      guard_q   <= guard_d;
      pending_q <= pending_d;
      trig_q    <= trig_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  assign adc_trigger  = trig_q;
  assign trig_pending = pending_q;
  assign overrun      = overrun_q;
  assign trig_count   = count_q;

endmodule

// File: tb/tb_axioma_adc_trigger.sv
// Self-checking bench for axioma_adc_trigger: directed scenarios followed by
// randomized stimulus, all compared cycle by cycle against a reference model.

module tb_axioma_adc_trigger;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       aden, adate;
  logic [2:0] adts;
  logic       adc_busy, adc_done;
  logic       src_acomp, src_int0, src_t0_compa, src_t0_ovf;
  logic       src_t1_compb, src_t1_ovf, src_t1_capt;
  logic       overrun_clr;
  logic       adc_trigger, trig_pending, overrun;
  logic [7:0] trig_count;

  int errors = 0;
  int checks = 0;

`ifdef AXIOMA_ADC_TRIG_SYNC_EN
  localparam int Int0Lat = 3;
`else
  localparam int Int0Lat = 1;
`endif

  // Reference model state: whole previous source vector rather than a single
  // previous-sample bit, plus INT0 sample history.
  logic [7:0] m_prev_vec;
  logic [2:0] m_adts_prev;
  logic [1:0] m_hist;
  logic       m_pending, m_guard, m_overrun, m_trig;
  logic [7:0] m_count;

  always #5 clk = ~clk;

  axioma_adc_trigger dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .aden         (aden),
    .adate        (adate),
    .adts         (adts),
    .adc_busy     (adc_busy),
    .adc_done     (adc_done),
    .src_acomp    (src_acomp),
    .src_int0     (src_int0),
    .src_t0_compa (src_t0_compa),
    .src_t0_ovf   (src_t0_ovf),
    .src_t1_compb (src_t1_compb),
    .src_t1_ovf   (src_t1_ovf),
    .src_t1_capt  (src_t1_capt),
    .overrun_clr  (overrun_clr),
    .adc_trigger  (adc_trigger),
    .trig_pending (trig_pending),
    .overrun      (overrun),
    .trig_count   (trig_count)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev_vec  = '0;
    m_adts_prev = '0;
    m_hist      = '0;
    m_pending   = 1'b0;
    m_guard     = 1'b0;
    m_overrun   = 1'b0;
    m_trig      = 1'b0;
    m_count     = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_edge();
    logic [7:0] v;
    logic       int0_seen, ev, busy, issue, lost;
`ifdef AXIOMA_ADC_TRIG_SYNC_EN
    int0_seen = m_hist[1];
`else
    int0_seen = src_int0;
`endif
    v = {src_t1_capt, src_t1_ovf, src_t1_compb, src_t0_ovf,
         src_t0_compa, int0_seen, src_acomp, adc_done};
    if (adts != m_adts_prev) ev = 1'b0;
    else if (adts == 3'd0)   ev = adc_done;
    else                     ev = v[adts] && !m_prev_vec[adts];
    m_prev_vec  = v;
    m_adts_prev = adts;
    m_hist      = {m_hist[0], src_int0};

    issue = 1'b0;
    lost  = 1'b0;
    if (!(aden && adate)) begin
      m_pending = 1'b0;
      m_guard   = 1'b0;
    end else begin
      busy = adc_busy || m_guard;
      if (!busy && (m_pending || ev)) begin
        issue     = 1'b1;
        m_pending = m_pending && ev;
      end else if (busy && ev) begin
        if (m_pending) lost = 1'b1;
        else           m_pending = 1'b1;
      end
      if (issue)         m_guard = 1'b1;
      else if (adc_busy) m_guard = 1'b0;
    end
    m_overrun = lost || (m_overrun && !overrun_clr);
    m_trig    = issue;
    m_count   = m_count + 8'(issue);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_trigger", 8'(adc_trigger), 8'(m_trig));
    chk("model_pending", 8'(trig_pending), 8'(m_pending));
    chk("model_overrun", 8'(overrun), 8'(m_overrun));
    chk("model_count", trig_count, m_count);
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    aden = 0; adate = 0; adts = 0; adc_busy = 0; adc_done = 0;
    src_acomp = 0; src_int0 = 0; src_t0_compa = 0; src_t0_ovf = 0;
    src_t1_compb = 0; src_t1_ovf = 0; src_t1_capt = 0; overrun_clr = 0;
    model_reset();
    #2;
    chk("reset_trigger", 8'(adc_trigger), 8'd0);
    chk("reset_pending", 8'(trig_pending), 8'd0);
    chk("reset_overrun", 8'(overrun), 8'd0);
    chk("reset_count", trig_count, 8'd0);
    aden = 1; adate = 1; adts = 3'd4;
    #1 reset_n = 1'b1;

    // Single Timer0 overflow edge: one trigger, one cycle wide.
    repeat (3) step();
    src_t0_ovf = 1;
    step();
    chk("t0ovf_trigger", 8'(adc_trigger), 8'd1);
    chk("t0ovf_count", trig_count, 8'd1);
    step();
    chk("t0ovf_one_cycle", 8'(adc_trigger), 8'd0);

    // Busy ADC: pending, then overrun, then issue when busy drops.
    adts = 3'd6; adc_busy = 1; src_t1_ovf = 0;
    step(); step();
    src_t1_ovf = 1; step();
    chk("busy_pending", 8'(trig_pending), 8'd1);
    src_t1_ovf = 0; step();
    src_t1_ovf = 1; step();
    chk("busy_overrun", 8'(overrun), 8'd1);
    chk("busy_pending_kept", 8'(trig_pending), 8'd1);
    adc_busy = 0; step();
    chk("pending_issue", 8'(adc_trigger), 8'd1);
    chk("pending_cleared", 8'(trig_pending), 8'd0);
    overrun_clr = 1; step();
    chk("overrun_clr", 8'(overrun), 8'd0);
    overrun_clr = 0;

    // Free-running: adc_done pulses.
    adts = 3'd0; adc_busy = 1; step();
    adc_busy = 0; step();
    adc_done = 1; step();
    chk("free_run_trigger", 8'(adc_trigger), 8'd1);
    adc_done = 0; adc_busy = 1; step();
    adc_done = 1; step();
    chk("free_run_pending", 8'(trig_pending), 8'd1);
    adc_done = 0; step(); step();
    chk("free_run_held", 8'(adc_trigger), 8'd0);
    adc_busy = 0; step();
    chk("free_run_late_trigger", 8'(adc_trigger), 8'd1);

    // Source switch onto an already-high flag must not trigger.
    adc_busy = 1; src_acomp = 1; adts = 3'd2; step();
    adc_busy = 0; step(); step();
    adts = 3'd1; step();
    chk("switch_no_trigger", 8'(adc_trigger), 8'd0);
    step();
    chk("switch_no_trigger2", 8'(adc_trigger), 8'd0);
    src_acomp = 0; step();
    src_acomp = 1; step();
    chk("acomp_edge_trigger", 8'(adc_trigger), 8'd1);

    // Disarm drops pending; re-arm waits for a fresh edge.
    adts = 3'd6; adc_busy = 1; src_t1_ovf = 0; step();
    src_t1_ovf = 1; step();
    chk("disarm_pre_pending", 8'(trig_pending), 8'd1);
    adate = 0; step();
    chk("disarm_pending_clr", 8'(trig_pending), 8'd0);
    chk("disarm_no_trigger", 8'(adc_trigger), 8'd0);
    adate = 1; adc_busy = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rearm_no_trigger", 8'(adc_trigger), 8'd0);
    end
    src_t1_ovf = 0; step();
    src_t1_ovf = 1; step();
    chk("rearm_new_edge", 8'(adc_trigger), 8'd1);

    // INT0 latency.
    adc_busy = 1; step();
    adc_busy = 0; adts = 3'd2; src_int0 = 0;
    repeat (4) step();
    src_int0 = 1;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (adc_trigger === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("int0_latency", 8'(lat), 8'(Int0Lat));

    // Randomized traffic with one asynchronous reset in the middle.
    for (int n = 0; n < 3000; n++) begin
      aden         = ($urandom_range(0, 19) != 0);
      adate        = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 39) == 0) adts = 3'($urandom);
      src_acomp    = src_acomp    ^ ($urandom_range(0, 3) == 0);
      src_int0     = src_int0     ^ ($urandom_range(0, 3) == 0);
      src_t0_compa = src_t0_compa ^ ($urandom_range(0, 3) == 0);
      src_t0_ovf   = src_t0_ovf   ^ ($urandom_range(0, 3) == 0);
      src_t1_compb = src_t1_compb ^ ($urandom_range(0, 3) == 0);
      src_t1_ovf   = src_t1_ovf   ^ ($urandom_range(0, 3) == 0);
      src_t1_capt  = src_t1_capt  ^ ($urandom_range(0, 3) == 0);
      adc_busy     = adc_busy     ^ ($urandom_range(0, 4) == 0);
      adc_done     = ($urandom_range(0, 5) == 0);
      overrun_clr  = ($urandom_range(0, 15) == 0);
      if (n == 1500) begin
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_trigger", 8'(adc_trigger), 8'd0);
        chk("midrun_reset_pending", 8'(trig_pending), 8'd0);
        chk("midrun_reset_overrun", 8'(overrun), 8'd0);
        chk("midrun_reset_count", trig_count, 8'd0);
        model_reset();
        #1 reset_n = 1'b1;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axioma_adc_trigger.md
# axioma_adc_trigger

ADC auto-trigger source selector and event arbiter, sitting directly upstream of the ADC controller and driving its `adc_trigger` input. It implements ATmega328P ADTS source selection (free-running, analog comparator, INT0, Timer0/Timer1 events) with rising-edge detection of the selected event flag. It holds a single pending trigger while a conversion is in progress, flags overruns, and counts issued triggers.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; the block's only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `aden`  in  1  ADCSRA.ADEN
- `adate`  in  1  ADCSRA.ADATE
- `adts`  in  3  ADCSRB[2:0] trigger source select
- `adc_busy`  in  1  ADC state != IDLE
- `adc_done`  in  1  one-cycle conversion-complete pulse from the ADC
- `src_acomp`  in  1  analog comparator interrupt flag (level)
- `src_int0`  in  1  external interrupt 0 flag/pin (level, may be asynchronous)
- `src_t0_compa`, `src_t0_ovf`, `src_t1_compb`, `src_t1_ovf`, `src_t1_capt`  in  1 each  timer interrupt flags (level)
- `overrun_clr`  in  1  clears `overrun`
- `adc_trigger`  out  1  one-cycle trigger pulse to the ADC, registered
- `trig_pending`  out  1  a trigger is held waiting for the ADC
- `overrun`  out  1  sticky: an event was lost
- `trig_count`  out  8  number of `adc_trigger` pulses issued; wraps

## Operation
- Source map by `adts`:
  - 0: free-running (event = `adc_done`)
  - 1: acomp
  - 2: int0
  - 3: t0_compa
  - 4: t0_ovf
  - 5: t1_compb
  - 6: t1_ovf
  - 7: t1_capt
- Edge detector:
  - `prev` holds the previous sample of the selected source.
  - event = sel & ~prev (sources 1–7); event = `adc_done` (source 0).
  - `prev` updates every cycle regardless of `aden`/`adate`.
  - In any cycle where `adts` differs from its registered copy, event is forced to 0 and `prev` loads the newly selected source. Switching sources never produces a spurious trigger.
- Arming: `armed` = `aden` & `adate`. When not armed, events are ignored and `trig_pending`/`guard` clear next cycle. `overrun` and `trig_count` are unaffected.
- `guard`:
  - Set with every issued trigger.
  - Cleared on the first cycle `adc_busy`=1, or when not armed.
  - Covers the one-cycle gap before the ADC leaves IDLE.
- `busy_eff` = `adc_busy` | `guard`.
- Per cycle, when armed:
  - `trig_pending` & ~`busy_eff`: issue (`adc_trigger`=1 next cycle), clear pending. A simultaneous event sets pending again.
  - Event & ~`trig_pending` & ~`busy_eff`: issue.
  - Event & ~`trig_pending` & `busy_eff`: set `trig_pending`.
  - Event & `trig_pending` & `busy_eff`: event lost, set `overrun`.
- At most one `adc_trigger` pulse per cycle. Pulses are never back-to-back, because `guard` is set.
- `overrun`: set has priority over `overrun_clr` in the same cycle.
- `trig_count`: +1 per `adc_trigger` pulse, 8-bit modulo (255 → 0).

## Timing
- Reset: all outputs 0; `prev`, `guard`, registered `adts` = 0.
- Reset mid-operation clears pending, guard and overrun immediately (asynchronous).
- Latency, source rising at sample edge N with ADC idle: `adc_trigger` high during cycle N+1, for exactly one cycle.
- Free-running: `adc_done` at cycle N → `adc_trigger` at N+1 provided `adc_busy`=0 by then. Otherwise the trigger goes pending and issues on the first cycle with `busy_eff`=0.
- Pending trigger: issues the cycle after `adc_busy` falls, provided `guard` is 0.
- `INT0` path: +2 cycles when synchronizer compiled in (see Configuration).

## Configuration
- `AXIOMA_ADC_TRIG_SYNC_EN` defined: `src_int0` passes through a 2-flop synchronizer (reset 0) before selection. INT0 latency = 3 cycles from the input edge.
- Not defined: `src_int0` is sampled directly, like other sources. INT0 latency = 1 cycle. The caller guarantees a synchronous input.

## Test plan
- Reset, aden=1, adate=1, adts=4, pulse `src_t0_ovf` 0→1 at cycle 10 → `adc_trigger`=1 only in cycle 11, `trig_count`=1.
- adts=6, ADC busy (`adc_busy`=1):
  - first `src_t1_ovf` rise → `trig_pending`=1
  - second rise while still busy → `overrun`=1, pending stays 1
  - `adc_busy` falls at cycle 50 → trigger at cycle 51, pending=0
  - `overrun_clr` → overrun=0
- adts=0, ADC idle, `adc_done` pulse at cycle 20 → trigger at 21. With `adc_busy` held 1 through 30 → pending, trigger at 31.
- `src_acomp` held 1, switch `adts` 2→1 → no trigger. Then acomp 0→1 → one trigger.
- adate=0 with pending set → pending clears next cycle, no trigger. Re-arm → no trigger until a new edge.
- With `AXIOMA_ADC_TRIG_SYNC_EN`: `src_int0` rises at cycle 5 (adts=2) → trigger at cycle 8. Without the macro → trigger at cycle 6.
